// File: rtl/hl2link_arb.sv
// Send-side arbiter for the HL2 inter-board link: command FIFO, stream/command
// arbitration with a starvation bound, and per-frame completion timeout with retry.
module hl2link_arb #(
    parameter int unsigned DW      = 24,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned CMD_DW  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_RUN = 8,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned FRAME_W = ADDR_W + CMD_DW,
    localparam int unsigned LW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               flush,
    input  logic               cmd_in_valid,
    input  logic [ADDR_W-1:0]  cmd_in_addr,
    input  logic [CMD_DW-1:0]  cmd_in_data,
    output logic               cmd_in_ready,
    input  logic               stream_valid,
    input  logic [DW-1:0]      stream_data,
    output logic               stream_done,
    output logic               send_tvalid,
    output logic [FRAME_W-1:0] send_tdata,
    output logic [1:0]         send_tuser,
    input  logic               send_tready,
    input  logic               send_tdone,
    output logic [LW-1:0]      cmd_level,
    output logic               link_timeout
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned RW = $clog2(MAX_RUN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_RUN);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t             state, state_d;
    logic [FRAME_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      count;
    logic [RW-1:0]      run_cnt;
    logic [TW-1:0]      to_cnt;
    logic               gnt_cmd;
    logic               drop_head;
    logic               fifo_empty, fifo_full, push, pop;
    logic               grant_cmd, grant_stream, frame_done, frame_abort, frame_end;
    logic               cmd_inflight;
    logic [FRAME_W-1:0] stream_frame;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == FULL_LVL);
    assign cmd_in_ready = ~fifo_full & ~flush;
    assign push         = cmd_in_valid & cmd_in_ready;
    assign frame_end    = frame_done | frame_abort;
    assign cmd_inflight = (state != S_IDLE) & gnt_cmd;
    // A flushed in-flight command is popped on timeout instead of being retried.
    assign pop          = gnt_cmd & (frame_done | (frame_abort & drop_head));

    assign cmd_level    = count;
    assign send_tvalid  = (state == S_SEND);
    assign stream_done  = frame_done & ~gnt_cmd;
    assign link_timeout = frame_abort;

    always_comb begin
        stream_frame = '0;
        stream_frame[FRAME_W-1 -: DW] = stream_data;
    end

    always_comb begin
        state_d      = state;
        grant_cmd    = 1'b0;
        grant_stream = 1'b0;
        frame_done   = 1'b0;
        frame_abort  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    if (~fifo_empty & ~flush & (~stream_valid | (run_cnt == RUN_LIMIT))) begin
                        grant_cmd = 1'b1;
                        state_d   = S_SEND;
                    end else if (stream_valid) begin
                        grant_stream = 1'b1;
                        state_d      = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (send_tready) begin
                    if (send_tdone) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (send_tdone) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    frame_abort = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_tdata <= '0;
            send_tuser <= '0;
            gnt_cmd    <= 1'b0;
        end else if (grant_cmd) begin
            send_tdata <= mem[rd_ptr];
            send_tuser <= 2'b01;
            gnt_cmd    <= 1'b1;
        end else if (grant_stream) begin
            send_tdata <= stream_frame;
            send_tuser <= 2'b10;
            gnt_cmd    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_in_addr, cmd_in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Keep only the head if it is still on the wire.
            if (cmd_inflight & ~frame_end) begin
                wr_ptr <= rd_ptr + 1'b1;
                count  <= LW'(1);
            end else begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)      count <= count + 1'b1;
            else if (pop & ~push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       drop_head <= 1'b0;
        else if (frame_end)               drop_head <= 1'b0;
        else if (flush & cmd_inflight)    drop_head <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     run_cnt <= '0;
        else if (fifo_empty | grant_cmd)                run_cnt <= '0;
        else if (grant_stream & (run_cnt != RUN_LIMIT)) run_cnt <= run_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    to_cnt <= '0;
        else if ((state == S_WAIT) & (state_d == S_WAIT)) to_cnt <= to_cnt + 1'b1;
        else                                           to_cnt <= '0;
    end

endmodule

// File: tb/tb_hl2link_arb.sv
// Directed bench for hl2link_arb: queue-based frame model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_hl2link_arb;

    localparam int DW = 24, ADDR_W = 6, CMD_DW = 32, DEPTH = 4, MAX_RUN = 8, TIMEOUT = 16;
    localparam int FRAME_W = ADDR_W + CMD_DW;

    logic clk = 0, rst_n = 0, enable = 0, flush = 0;
    logic cmd_in_valid = 0;
    logic [ADDR_W-1:0] cmd_in_addr = '0;
    logic [CMD_DW-1:0] cmd_in_data = '0;
    logic cmd_in_ready;
    logic stream_valid = 0;
    logic [DW-1:0] stream_data = '0;
    logic stream_done, send_tvalid;
    logic [FRAME_W-1:0] send_tdata;
    logic [1:0] send_tuser;
    logic send_tready = 0, send_tdone = 0;
    logic [2:0] cmd_level;
    logic link_timeout;

    hl2link_arb #(.DW(DW), .ADDR_W(ADDR_W), .CMD_DW(CMD_DW), .DEPTH(DEPTH),
                  .MAX_RUN(MAX_RUN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .cmd_in_valid(cmd_in_valid), .cmd_in_addr(cmd_in_addr), .cmd_in_data(cmd_in_data),
        .cmd_in_ready(cmd_in_ready), .stream_valid(stream_valid), .stream_data(stream_data),
        .stream_done(stream_done), .send_tvalid(send_tvalid), .send_tdata(send_tdata),
        .send_tuser(send_tuser), .send_tready(send_tready), .send_tdone(send_tdone),
        .cmd_level(cmd_level), .link_timeout(link_timeout));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: queue of pending commands plus the frame on the wire.
    logic [FRAME_W-1:0] q[$];
    bit m_busy = 0, m_acc = 0, m_cmd = 0, m_doom = 0;
    int m_wait = 0, m_streak = 0;
    logic [FRAME_W-1:0] m_data = '0;

    initial begin
        int pre;
        bit was_busy, done_f, abort_f, keep_f, push_f;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_busy = 0; m_acc = 0; m_cmd = 0; m_doom = 0; m_wait = 0; m_streak = 0;
            end else begin
                pre = q.size();
                was_busy = m_busy;
                done_f = 0; abort_f = 0;
                push_f = cmd_in_valid && pre < DEPTH && !flush;
                if (m_busy && !m_acc) begin
                    if (send_tready) begin
                        if (send_tdone) done_f = 1;
                        else begin m_acc = 1; m_wait = 0; end
                    end
                end else if (m_busy) begin
                    if (send_tdone) done_f = 1;
                    else if (m_wait == TIMEOUT - 1) abort_f = 1;
                    else m_wait++;
                end
                keep_f = flush && m_busy && m_cmd && !done_f && !abort_f;
                if (!was_busy && enable) begin
                    if (pre > 0 && !flush && (!stream_valid || m_streak == MAX_RUN)) begin
                        m_data = q[0]; m_cmd = 1; m_busy = 1; m_acc = 0; m_streak = 0;
                    end else if (stream_valid) begin
                        m_data = FRAME_W'(stream_data) << (FRAME_W - DW);
                        m_cmd = 0; m_busy = 1; m_acc = 0;
                        if (pre > 0 && m_streak < MAX_RUN) m_streak++;
                    end
                end
                if (pre == 0) m_streak = 0;
                if (done_f || abort_f) begin
                    if (m_cmd && (done_f || m_doom)) void'(q.pop_front());
                    m_busy = 0; m_acc = 0; m_doom = 0;
                end
                if (flush) begin
                    if (keep_f) begin
                        logic [FRAME_W-1:0] h;
                        h = q[0]; q.delete(); q.push_back(h); m_doom = 1;
                    end else q.delete();
                end
                if (push_f) q.push_back({cmd_in_addr, cmd_in_data});
            end
        end
    end

    logic [1:0] gnt_log[$];
    int sdone_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            chk("tvalid", send_tvalid, m_busy && !m_acc);
            if (m_busy && !m_acc) begin
                chk("tdata", send_tdata, m_data);
                chk("tuser", send_tuser, m_cmd ? 2'b01 : 2'b10);
            end
            chk("level", cmd_level, q.size());
            chk("ready", cmd_in_ready, q.size() < DEPTH && !flush);
            chk("stream_done", stream_done,
                m_busy && !m_cmd && send_tdone && (m_acc || send_tready));
            chk("link_timeout", link_timeout,
                m_busy && m_acc && !send_tdone && m_wait == TIMEOUT - 1);
            if (send_tvalid && send_tready) gnt_log.push_back(send_tuser);
            if (stream_done) sdone_cnt++;
        end
    end

    // Link responder: 0 idle, 1 accept then done two cycles later, 2 accept never done, 3 manual.
    int lk_mode = 0, lk_cnt = -1;
    logic man_tready = 0, man_tdone = 0;
    initial begin
        forever begin
            @(posedge clk); #2;
            send_tready = 0; send_tdone = 0;
            case (lk_mode)
                1: begin
                    if (lk_cnt >= 0) begin
                        lk_cnt++;
                        if (lk_cnt == 2) begin send_tdone = 1; lk_cnt = -1; end
                    end else if (send_tvalid) begin
                        send_tready = 1; lk_cnt = 0;
                    end
                end
                2: send_tready = send_tvalid;
                3: begin send_tready = man_tready; send_tdone = man_tdone; end
                default: ;
            endcase
            if (lk_mode != 1) lk_cnt = -1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int n, g, ns, nv;
        cyc(2);
        @(negedge clk);
        chk("rst_tvalid", send_tvalid, 0);
        chk("rst_tdata", send_tdata, 0);
        chk("rst_tuser", send_tuser, 0);
        chk("rst_level", cmd_level, 0);
        chk("rst_ready", cmd_in_ready, 1);
        chk("rst_sdone", stream_done, 0);
        chk("rst_tout", link_timeout, 0);
        cyc(1); rst_n = 1; enable = 1; lk_mode = 3;

        // tdone while idle must be ignored
        man_tdone = 1; cyc(1); man_tdone = 0;
        @(negedge clk); chk("idle_tdone_level", cmd_level, 0);

        // single command
        cyc(1); cmd_in_valid = 1; cmd_in_addr = 6'h39; cmd_in_data = 32'h0000_0109;
        cyc(1); cmd_in_valid = 0;
        @(negedge clk); chk("t1_pre_tvalid", send_tvalid, 0); chk("t1_level1", cmd_level, 1);
        cyc(1);
        @(negedge clk);
        chk("t1_tvalid", send_tvalid, 1); chk("t1_tuser", send_tuser, 2'b01);
        chk("t1_tdata", send_tdata, 38'h39_0000_0109);
        cyc(1); man_tready = 1;
        cyc(1); man_tready = 0;
        @(negedge clk); chk("t1_wait_tvalid", send_tvalid, 0);
        cyc(2); man_tdone = 1;
        @(negedge clk); chk("t1_level_before_done", cmd_level, 1);
        cyc(1); man_tdone = 0;
        @(negedge clk); chk("t1_level_after_done", cmd_level, 0);

        // starvation bound
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1); cmd_in_valid = 1; cmd_in_addr = 6'(i + 1); cmd_in_data = 32'hC0DE_0000 + i;
        end
        cyc(1); cmd_in_valid = 0;
        @(negedge clk); chk("starve_level", cmd_level, 3);
        gnt_log.delete(); sdone_cnt = 0;
        cyc(1); lk_mode = 1; stream_valid = 1; stream_data = 24'hABCDEF; enable = 1;
        cyc(1);
        @(negedge clk);
        chk("stream_tuser", send_tuser, 2'b10);
        chk("stream_tdata", send_tdata, 38'h2A_F37B_C000);
        n = 0;
        while (gnt_log.size() < 27 && n < 400) begin @(negedge clk); n++; end
        chk("starve_frames", gnt_log.size() >= 27, 1);
        for (int i = 0; i < 27 && i < gnt_log.size(); i++)
            chk("starve_seq", gnt_log[i], (i % 9 == 8) ? 2'b01 : 2'b10);
        n = 0;
        while (!stream_done && n < 50) begin @(negedge clk); n++; end
        chk("starve_last_done", stream_done, 1);
        cyc(1); stream_valid = 0;
        cyc(4);
        ns = 0;
        foreach (gnt_log[i]) if (gnt_log[i] == 2'b10) ns++;
        @(negedge clk);
        chk("sdone_count", sdone_cnt, ns);
        chk("starve_end_level", cmd_level, 0);

        // full FIFO with a stalled link
        lk_mode = 3;
        cyc(1); cmd_in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            cmd_in_addr = 6'(8 + i); cmd_in_data = 32'hF000_0000 + i;
            if (i == 4) begin
                @(negedge clk);
                chk("full_ready", cmd_in_ready, 0); chk("full_level", cmd_level, 4);
            end
            cyc(1);
        end
        cmd_in_valid = 0;
        @(negedge clk); chk("full_reject_level", cmd_level, 4);
        cyc(1); man_tready = 1; man_tdone = 1;
        cyc(1); man_tready = 0; man_tdone = 0;
        @(negedge clk); chk("full_pop_level", cmd_level, 3);
        cyc(1); cmd_in_valid = 1; cmd_in_addr = 6'h2A; cmd_in_data = 32'h55;
        man_tready = 1; man_tdone = 1;
        cyc(1); cmd_in_valid = 0; man_tready = 0; man_tdone = 0;
        @(negedge clk); chk("pushpop_level", cmd_level, 3);
        lk_mode = 1;
        n = 0;
        while (cmd_level != 0 && n < 100) begin @(negedge clk); n++; end
        chk("full_drain", cmd_level, 0);

        // timeout and retry
        cyc(1); lk_mode = 2; cmd_in_valid = 1; cmd_in_addr = 6'h11; cmd_in_data = 32'hDEAD_BEEF;
        cyc(1); cmd_in_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(send_tvalid && send_tready) && n < 20);
        g = 0;
        while (!link_timeout && g < 100) begin @(negedge clk); g++; end
        chk("timeout_gap", g, 16);
        chk("timeout_level", cmd_level, 1);
        cyc(1); lk_mode = 1;
        cyc(1);
        @(negedge clk);
        chk("retry_tvalid", send_tvalid, 1);
        chk("retry_tdata", send_tdata, {6'h11, 32'hDEAD_BEEF});
        chk("retry_level", cmd_level, 1);
        n = 0;
        while (cmd_level != 0 && n < 50) begin @(negedge clk); n++; end
        chk("retry_done", cmd_level, 0);

        // flush with a command in WAIT
        cyc(1); lk_mode = 3; enable = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1); cmd_in_valid = 1; cmd_in_addr = 6'(20 + i); cmd_in_data = 32'hF1F1_0000 + i;
        end
        cyc(1); cmd_in_valid = 0; enable = 1;
        cyc(1); man_tready = 1;
        cyc(1); man_tready = 0; flush = 1;
        @(negedge clk); chk("flush_ready", cmd_in_ready, 0);
        cyc(1); flush = 0;
        @(negedge clk); chk("flush_level1", cmd_level, 1);
        cyc(2); man_tdone = 1;
        cyc(1); man_tdone = 0;
        @(negedge clk); chk("flush_level0", cmd_level, 0);
        nv = 0;
        repeat (12) begin @(negedge clk); if (send_tvalid) nv++; end
        chk("flush_no_more_frames", nv, 0);

        // async reset while in SEND
        lk_mode = 0;
        cyc(1); cmd_in_valid = 1; cmd_in_addr = 6'h3F; cmd_in_data = 32'h1234_5678;
        cyc(1); cmd_in_valid = 0;
        cyc(1);
        @(negedge clk); chk("ar_tvalid_before", send_tvalid, 1);
        cyc(1); #2; rst_n = 0; #1;
        chk("ar_tvalid", send_tvalid, 0);
        chk("ar_level", cmd_level, 0);
        chk("ar_sdone", stream_done, 0);
        chk("ar_tout", link_timeout, 0);
        cyc(2); rst_n = 1;
        cyc(3);
        @(negedge clk);
        chk("ar_after_tvalid", send_tvalid, 0);
        chk("ar_after_level", cmd_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
